// File: rtl/cpsk_pkg.sv
// Shared CPSK constants: carrier pattern, FSM encoding and counter sizing.
// Used by both the modulator and the demodulator.
package cpsk_pkg;

  localparam int unsigned CARRIER_LEN = 4;
  localparam int unsigned PHASE_W     = 2;
  localparam int unsigned CPB_MAX     = 64;

  // Reference carrier level indexed by phase: high for phases 0,1.
  localparam logic [CARRIER_LEN-1:0] REF_PATTERN = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Width needed to count every sample of the longest legal bit window.
  function automatic int unsigned agree_width(input int unsigned cpb_max);
    return $clog2(CARRIER_LEN * cpb_max + 1);
  endfunction

endpackage

// File: rtl/cpsk_demodulator_if.sv
// Line-side and decision-side signals of the CPSK demodulator.
interface cpsk_demodulator_if;
  logic start;
  logic y_in;
  logic x_out;
  logic x_valid;
  logic ambig;

  modport master (output start, output y_in, input x_out, input x_valid, input ambig);
  modport slave  (input start, input y_in, output x_out, output x_valid, output ambig);
endinterface

// File: rtl/cpsk_carrier_gen.sv
// Local 4-clock reference carrier: phase counter, reference level and last-phase strobe.
module cpsk_carrier_gen
  import cpsk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic ref_c,
  output logic ph_last_c
);

  logic [PHASE_W-1:0] phase;

  // Phase wraps 3->0 naturally through the 2-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + PHASE_W'(1);
    end
  end

  assign ref_c     = REF_PATTERN[phase];
  assign ph_last_c = (phase == PHASE_W'(CARRIER_LEN - 1));

endmodule

// File: rtl/cpsk_demodulator.sv
// Coherent 2-level CPSK demodulator: integrates line/reference agreement over
// each bit window and emits a majority decision with an ambiguity flag.
module cpsk_demodulator
  import cpsk_pkg::*;
#(
  parameter int unsigned CARRIERS_PER_BIT = 4,
  parameter int unsigned ALIGN_DLY        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cpsk_demodulator_if.slave   bus
);

  localparam int unsigned AGREE_W = agree_width(CPB_MAX);
  localparam int unsigned CAR_W   = $clog2(CPB_MAX);
  localparam int unsigned DLY_W   = 3;
  localparam int unsigned WIN_LEN = CARRIER_LEN * CARRIERS_PER_BIT;

  localparam logic [AGREE_W-1:0] HALF     = AGREE_W'(WIN_LEN / 2);
  localparam logic [CAR_W-1:0]   CAR_LAST = CAR_W'(CARRIERS_PER_BIT - 1);
  localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(ALIGN_DLY - 1);

  state_e               state_q, state_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [CAR_W-1:0]     car_q, car_d;
  logic [AGREE_W-1:0]   agree_q, agree_d;
  logic                 x_q, x_d;
  logic                 valid_q, valid_d;
  logic                 ambig_q, ambig_d;

  logic                 run_c;
  logic                 ref_c;
  logic                 ph_last_c;
  logic [AGREE_W-1:0]   agree_sum_c;

  assign run_c       = bus.start && (state_q == ST_RUN);
  assign agree_sum_c = agree_q + AGREE_W'(bus.y_in == ref_c);

  // Carrier is held at phase 0 until the FSM is actually sampling.
  cpsk_carrier_gen u_carrier (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!run_c),
    .en        (run_c),
    .ref_c     (ref_c),
    .ph_last_c (ph_last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      car_q   <= '0;
      agree_q <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      ambig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      car_q   <= car_d;
      agree_q <= agree_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      ambig_q <= ambig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    car_d   = car_q;
    agree_d = agree_q;
    x_d     = x_q;
    valid_d = 1'b0;
    ambig_d = ambig_q;

    if (!bus.start) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      car_d   = '0;
      agree_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dly_d   = '0;
          car_d   = '0;
          agree_d = '0;
          state_d = (ALIGN_DLY == 0) ? ST_RUN : ST_ALIGN;
        end
        ST_ALIGN: begin
          dly_d = dly_q + DLY_W'(1);
          if (dly_q == DLY_LAST) begin
            state_d = ST_RUN;
            dly_d   = '0;
            car_d   = '0;
            agree_d = '0;
          end
        end
        ST_RUN: begin
          agree_d = agree_sum_c;
          if (ph_last_c) begin
            if (car_q == CAR_LAST) begin
              // Window end: the current sample is already in agree_sum_c.
              car_d   = '0;
              agree_d = '0;
              valid_d = 1'b1;
              if (agree_sum_c > HALF) begin
                x_d     = 1'b1;
                ambig_d = 1'b0;
              end else if (agree_sum_c < HALF) begin
                x_d     = 1'b0;
                ambig_d = 1'b0;
              end else begin
                ambig_d = 1'b1;
              end
            end else begin
              car_d = car_q + CAR_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.x_out   = x_q;
  assign bus.x_valid = valid_q;
  assign bus.ambig   = ambig_q;

endmodule

// File: tb/tb_cpsk_demodulator.sv
// Scoreboard bench for cpsk_demodulator: directed line patterns, decisions
// checked by a monitor against expected bit, flag and arrival cycle.
module tb_cpsk_demodulator;

  localparam int unsigned ALIGN = 1;

  typedef struct {
    int   at;
    logic x;
    logic amb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t exp_q[$];
  int   t0 = 0;
  int   win = 0;
  int   tb0 = 0;
  int   amb_n = 0;

  cpsk_demodulator_if ifa ();
  cpsk_demodulator_if ifb ();

  cpsk_demodulator #(.CARRIERS_PER_BIT(4), .ALIGN_DLY(ALIGN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  cpsk_demodulator #(.CARRIERS_PER_BIT(1), .ALIGN_DLY(0)) dut_amb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: every decision must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (ifa.x_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d x=%b ambig=%b", cyc, ifa.x_out, ifa.ambig);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.at || ifa.x_out !== e.x || ifa.ambig !== e.amb) begin
          bad++;
          $display("FAIL window cyc/x/ambig got %0d/%b/%b expected %0d/%b/%b",
                   cyc, ifa.x_out, ifa.ambig, e.at, e.x, e.amb);
        end
      end
    end
  end

  // One-carrier instance with the line tied high: always exactly half agreement.
  always @(posedge clk) begin
    #1;
    if (ifb.x_valid === 1'b1) begin
      total++;
      amb_n++;
      if (ifb.ambig !== 1'b1 || ifb.x_out !== 1'b0 || cyc != tb0 + 4 * amb_n) begin
        bad++;
        $display("FAIL amb_window cyc/x/ambig got %0d/%b/%b expected %0d/0/1",
                 cyc, ifb.x_out, ifb.ambig, tb0 + 4 * amb_n);
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic begin_run();
    @(negedge clk);
    ifa.start = 1'b1;
    t0  = cyc + 1;
    win = 0;
    repeat (ALIGN) @(negedge clk);
  endtask

  task automatic send_window(input logic [15:0] y, input logic ex, input logic eamb);
    exp_t e;
    e.at  = t0 + int'(ALIGN) + 16 * (win + 1);
    e.x   = ex;
    e.amb = eamb;
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ifa.y_in = y[i];
    end
    win++;
  endtask

  task automatic send_partial(input logic [15:0] y, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.y_in = y[i];
    end
  endtask

  localparam logic [15:0] ONE  = 16'h3333;
  localparam logic [15:0] ZERO = 16'hCCCC;

  initial begin
    rst_n     = 1'b0;
    ifa.start = 1'b0;
    ifa.y_in  = 1'b0;
    ifb.start = 1'b0;
    ifb.y_in  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_x_out", ifa.x_out, 1'b0);
    check("reset_x_valid", ifa.x_valid, 1'b0);
    check("reset_ambig", ifa.ambig, 1'b0);
    rst_n = 1'b1;

    // Ambiguity instance: five full 4-clock windows, then stop.
    @(negedge clk);
    ifb.start = 1'b1;
    tb0 = cyc + 1;
    repeat (22) @(negedge clk);
    ifb.start = 1'b0;

    // Loopback pattern, inverted line, noise margins and ambiguity hold.
    begin_run();
    send_window(ONE, 1'b1, 1'b0);
    send_window(ZERO, 1'b0, 1'b0);
    send_window(ONE, 1'b1, 1'b0);
    send_window(ONE, 1'b1, 1'b0);
    send_window(ZERO, 1'b0, 1'b0);
    send_window(ZERO, 1'b0, 1'b0);
    send_window(ONE ^ 16'h007F, 1'b1, 1'b0);
    send_window(ONE ^ 16'h01FF, 1'b0, 1'b0);
    send_window(ONE ^ 16'h003F, 1'b1, 1'b0);
    send_window(ONE ^ 16'h00FF, 1'b1, 1'b1);
    send_window(ZERO, 1'b0, 1'b0);
    send_window(ONE ^ 16'h00FF, 1'b0, 1'b1);
    send_window(ONE, 1'b1, 1'b0);

    // Interrupted window: no decision, x_out held, clean restart.
    send_partial(ZERO, 10);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_x_out_hold", ifa.x_out, 1'b1);
    check("idle_x_valid", ifa.x_valid, 1'b0);
    @(negedge clk);
    begin_run();
    send_window(ZERO, 1'b0, 1'b0);
    send_window(ONE, 1'b1, 1'b0);

    // Asynchronous reset between edges, mid-window.
    send_partial(ONE, 6);
    check("pre_reset_x_out", ifa.x_out, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_x_out", ifa.x_out, 1'b0);
    check("async_rst_x_valid", ifa.x_valid, 1'b0);
    check("async_rst_ambig", ifa.ambig, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    t0  = cyc + 1;
    win = 0;
    repeat (ALIGN) @(negedge clk);
    send_window(ONE, 1'b1, 1'b0);
    send_window(ONE ^ 16'h01FF, 1'b0, 1'b0);

    @(negedge clk);
    ifa.start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_decisions got %0d pending expected 0", exp_q.size());
    end
    total++;
    if (amb_n != 5) begin
      bad++;
      $display("FAIL amb_count got %0d expected 5", amb_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpsk_demodulator.md
Name: cpsk_demodulator

Overview:
- Coherent demodulator for the 2-level CPSK stream produced by the modulator stage; sits directly downstream of it and recovers the baseband bit stream.
- Regenerates the 4-clock reference carrier locally, aligned to the shared start strobe, and integrates agreement between the received line and the reference over each bit window.
- Emits one decided bit per window with a valid pulse and an ambiguity flag.

Parameters:
- CARRIERS_PER_BIT, 4, carrier periods (4 clocks each) per bit window; legal range 1..64.
- ALIGN_DLY, 1, clocks between start rising and the first sample counted, compensating modulator output latency; legal range 0..7.

Ports:
- clk  input  1  system clock, same clock as the modulator.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  enable, shared with the modulator; high = run, low = synchronous return to IDLE.
- y_in  input  1  received CPSK line (modulator output).
- x_out  output  1  recovered bit, held between decisions.
- x_valid  output  1  one-clock pulse when x_out is updated.
- ambig  output  1  valid with x_valid; high when the window agreement count equals exactly half.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all counters 0, x_out=0, x_valid=0, ambig=0.
- States:
  - IDLE: wait for start=1. On the first cycle start is seen high, go to ALIGN with dly_cnt=0, or directly to RUN if ALIGN_DLY=0.
  - ALIGN: dly_cnt increments each clock. At dly_cnt=ALIGN_DLY-1, go to RUN with phase=0, car_cnt=0, agree=0.
  - RUN: sample and decide as below.
- start=0 in any state: next clock goes to IDLE and clears counters. x_out keeps its value; x_valid is forced to 0. A window interrupted mid-way produces no decision.
- Reference carrier in RUN: ref=1 for phase 0,1 and ref=0 for phase 2,3. phase is a 2-bit counter that wraps 3→0.
- Each RUN clock:
  - agree increments when y_in==ref.
  - car_cnt increments when phase==3; it wraps at CARRIERS_PER_BIT-1.
- Window end (phase==3 and car_cnt==CARRIERS_PER_BIT-1): the current sample is included in the total. Let N=4*CARRIERS_PER_BIT and A=final agree.
  - A>N/2: x_out<=1, ambig<=0.
  - A<N/2: x_out<=0, ambig<=0.
  - A==N/2: x_out holds its previous value, ambig<=1.
  - x_valid<=1 for exactly that clock. agree restarts at 0 on the next clock with no dead cycle between windows.
- Latency: x_out/x_valid register on the clock edge after the last sample of a window.
- agree width: clog2(4*64+1)=9 bits. No overflow is possible within the legal range.
- Decisions continue back-to-back while start stays high. There is no input handshake; the output has no backpressure.

Decomposition:
- Shared package cpsk_pkg holds:
  - CARRIER_LEN=4 and the reference pattern constant (4'b0011, indexed by phase).
  - State encoding for IDLE/ALIGN/RUN.
  - The agree counter width function.
- The modulator stage reuses the same constants.
- Sub-module cpsk_carrier_gen: phase counter plus reference output, reset and clear inputs, phase==3 strobe. The demodulator datapath and FSM stay in the top module.

Test Plan:
- Loopback with the modulator, defaults: feed x=1,0,1,1,0 each held 16 clocks after start rises → x_valid pulses every 16 clocks; x_out sequence 1,0,1,1,0; ambig=0 throughout.
- Inverted line, y_in=~modulator output for x=1 → every window gives A=0, x_out=0, ambig=0.
- Ambiguity with CARRIERS_PER_BIT=1, y_in tied to 1 (A=2 of 4) → x_valid every 4 clocks, ambig=1, x_out holds its prior value (0 after reset).
- Noise tolerance: x=1 window with 7 of 16 samples flipped (A=9) → x_out=1. With 9 flipped (A=7) → x_out=0.
- start dropped after 10 clocks of RUN, re-raised 5 clocks later → no x_valid during the partial window. The next x_valid arrives exactly ALIGN_DLY+16 clocks after the re-rise edge is sampled.
- rst_n asserted mid-window, asynchronously between edges → x_out, x_valid and ambig read 0 immediately, before the next clock. After release with start high, the first x_valid appears ALIGN_DLY+16 clocks later.
